heading_integrator: RTL and testbench

//  Consumes yaw-rate samples (yaw_rt/vld) from the inertial SPI interface and produces robot heading.

---
 rtl/heading_pkg.sv | 16 +
 rtl/yaw_cal_avg.sv | 46 ++++
 rtl/heading_integrator.sv | 120 ++++++++++++
 tb/tb_heading_integrator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/heading_pkg.sv
// Shared types and widths for the heading integrator and its calibration averager.
package heading_pkg;

    typedef enum logic [1:0] {IDLE, CAL, RUN} hdg_state_t;

    localparam int YAW_W   = 16;   // gyro yaw-rate sample width
    localparam int ACC_W   = 27;   // calibration sum and heading integrator width
    localparam int HDG_W   = 12;   // published heading width
    localparam int HDG_LSB = 15;   // integrator bit that maps to heading bit 0

    // Calibration window length (log2 of sample count): short for simulation, long for hardware.
    function automatic int cal_log2(input int fast_sim);
        return (fast_sim != 0) ? 8 : 11;
    endfunction

endpackage

// File: rtl/yaw_cal_avg.sv
// Gyro zero-rate offset averager: sums 2^CAL_LOG2 samples and publishes their arithmetic mean.
module yaw_cal_avg
    import heading_pkg::*;
#(
    parameter int CAL_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc_en,
    input  logic [YAW_W-1:0] yaw_rt,
    output logic [YAW_W-1:0] yaw_off,
    output logic             last
);

    logic signed [ACC_W-1:0] cal_sum;
    logic signed [ACC_W-1:0] sum_next;
    logic [CAL_LOG2-1:0]     cal_cnt;
    logic [YAW_W-1:0]        off_next;

    // Running sum including the sample presented this cycle, so the final sample is averaged in
    assign sum_next = cal_sum + {{(ACC_W-YAW_W){yaw_rt[YAW_W-1]}}, yaw_rt};
    assign off_next = YAW_W'(sum_next >>> CAL_LOG2);

    // The counter sits at all-ones while waiting for the last sample of the window
    assign last = acc_en && (cal_cnt == '1);

    // Accumulate samples; latch the mean on the last one; a restart clears the window but keeps the old offset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cal_sum <= '0;
            cal_cnt <= '0;
            yaw_off <= '0;
        end else if (clr) begin
            cal_sum <= '0;
            cal_cnt <= '0;
        end else if (acc_en) begin
            cal_sum <= sum_next;
            cal_cnt <= cal_cnt + 1'b1;
            if (last) begin
                yaw_off <= off_next;
            end
        end
    end

endmodule

// File: rtl/heading_integrator.sv
// Robot heading integrator: gyro offset calibration, deadbanded rate integration and IR fusion.
module heading_integrator
    import heading_pkg::*;
#(
    parameter int FAST_SIM  = 1,
    parameter int DEADBAND  = 16,
    parameter int FUS_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_cal,
    input  logic             vld,
    input  logic [YAW_W-1:0] yaw_rt,
    input  logic             moving,
    input  logic             en_fusion,
    input  logic [8:0]       IR_Dtrm,
    output logic             cal_done,
    output logic             rdy,
    output logic [HDG_W-1:0] heading
);

    localparam int CAL_LOG2 = cal_log2(FAST_SIM);
    localparam logic signed [YAW_W:0] DB = (YAW_W+1)'(DEADBAND);

    hdg_state_t state;
    hdg_state_t state_next;

    logic acc_en;
    logic cal_last;
    logic int_en;
    logic rdy_next;

    logic [YAW_W-1:0]        yaw_off;
    logic signed [YAW_W:0]   yaw_comp_raw;
    logic signed [YAW_W:0]   yaw_comp;
    logic [ACC_W-1:0]        fus_term;
    logic [ACC_W-1:0]        yaw_int;
    logic [ACC_W-1:0]        yaw_int_next;

    // A restart request always wins over a sample arriving in the same cycle
    assign acc_en = (state == CAL) && vld && !strt_cal;

    yaw_cal_avg #(
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal (
        .clk     (clk),
        .rst     (rst),
        .clr     (strt_cal),
        .acc_en  (acc_en),
        .yaw_rt  (yaw_rt),
        .yaw_off (yaw_off),
        .last    (cal_last)
    );

    // Mode sequencing and per-sample control strobes
    always_comb begin
        state_next = state;
        int_en     = 1'b0;
        rdy_next   = 1'b0;
        if (strt_cal) begin
            state_next = CAL;
        end else begin
            case (state)
                IDLE: ;
                CAL: begin
                    if (cal_last) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (vld) begin
                        rdy_next = 1'b1;
                        int_en   = moving;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Offset-corrected rate with small magnitudes squashed to zero (gyro noise rejection)
    assign yaw_comp_raw = {yaw_rt[YAW_W-1], yaw_rt} - {yaw_off[YAW_W-1], yaw_off};
    assign yaw_comp     = ((yaw_comp_raw > -DB) && (yaw_comp_raw < DB)) ? '0 : yaw_comp_raw;

    // Guard-rail correction, scaled up into integrator units
    assign fus_term = en_fusion ? ({{(ACC_W-9){IR_Dtrm[8]}}, IR_Dtrm} << FUS_SHIFT) : '0;

    // Integrator wraps modulo 2^ACC_W so heading is circular
    assign yaw_int_next = yaw_int + {{(ACC_W-YAW_W-1){yaw_comp[YAW_W]}}, yaw_comp} + fus_term;

    // Integrator, heading and strobe output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yaw_int  <= '0;
            heading  <= '0;
            rdy      <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            rdy      <= rdy_next;
            cal_done <= cal_last;
            if (strt_cal) begin
                yaw_int <= '0;
                heading <= '0;
            end else if (int_en) begin
                yaw_int <= yaw_int_next;
                heading <= yaw_int_next[ACC_W-1:HDG_LSB];
            end
        end
    end

endmodule

// File: tb/tb_heading_integrator.sv
// Bench for heading_integrator: directed corner sequences, a vector table and a randomized run
// checked against a behavioural model of the calibration/integration rules.
module tb_heading_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cal;
    logic        vld;
    logic [15:0] yaw_rt;
    logic        moving;
    logic        en_fusion;
    logic [8:0]  IR_Dtrm;
    logic        cal_done;
    logic        rdy;
    logic [11:0] heading;

    always #5 clk = ~clk;

    heading_integrator #(
        .FAST_SIM  (1),
        .DEADBAND  (16),
        .FUS_SHIFT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cal  (strt_cal),
        .vld       (vld),
        .yaw_rt    (yaw_rt),
        .moving    (moving),
        .en_fusion (en_fusion),
        .IR_Dtrm   (IR_Dtrm),
        .cal_done  (cal_done),
        .rdy       (rdy),
        .heading   (heading)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 calibrating, 2 running
    int                 m_mode;
    longint             m_sum;
    int                 m_cnt;
    logic signed [15:0] m_off;
    logic [26:0]        m_int;
    logic               m_rdy;
    logic               m_cd;

    typedef struct {
        logic        vld;
        logic [15:0] yaw;
        logic        exp_rdy;
        logic [11:0] exp_hdg;
    } vec_t;

    vec_t tbl[16];

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_sum  = 0;
        m_cnt  = 0;
        m_off  = 16'sd0;
        m_int  = '0;
        m_rdy  = 1'b0;
        m_cd   = 1'b0;
    endtask

    task automatic model_update(input logic s, input logic v, input logic [15:0] y,
                                input logic m, input logic f, input logic [8:0] ir);
        int     comp;
        longint d;
        m_rdy = 1'b0;
        m_cd  = 1'b0;
        if (s) begin
            m_mode = 1;
            m_sum  = 0;
            m_cnt  = 0;
            m_int  = '0;
        end else if (v && m_mode == 1) begin
            m_sum += longint'($signed(y));
            m_cnt++;
            if (m_cnt == 256) begin
                m_off  = 16'(m_sum >>> 8);
                m_mode = 2;
                m_cd   = 1'b1;
            end
        end else if (v && m_mode == 2) begin
            comp = int'($signed(y)) - int'(m_off);
            if (comp > -16 && comp < 16) comp = 0;
            m_rdy = 1'b1;
            if (m) begin
                d = longint'(comp);
                if (f) d += longint'($signed(ir)) * 16;
                m_int = 27'(longint'(m_int) + d);
            end
        end
    endtask

    // One clock: drive, let the edge sample, update the model, then compare just after the edge
    task automatic step(input logic s, input logic v, input logic [15:0] y,
                        input logic m, input logic f, input logic [8:0] ir);
        strt_cal  = s;
        vld       = v;
        yaw_rt    = y;
        moving    = m;
        en_fusion = f;
        IR_Dtrm   = ir;
        @(posedge clk);
        model_update(s, v, y, m, f, ir);
        #1;
        check("rdy", rdy, m_rdy);
        check("cal_done", cal_done, m_cd);
        check("heading", heading, m_int[26:15]);
    endtask

    // Calibrate with a sample every other clock
    task automatic calibrate(input logic [15:0] y);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 9'h0);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, y, 1'b0, 1'b0, 9'h0);
            if (i < 255) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 9'h0);
        end
    endtask

    initial begin
        rst = 1'b1; strt_cal = 1'b0; vld = 1'b0; yaw_rt = '0;
        moving = 1'b0; en_fusion = 1'b0; IR_Dtrm = '0;
        model_reset();

        for (int k = 0; k < 8; k++) begin
            tbl[2*k]   = '{1'b1, 16'h1040, 1'b1, 12'(((k + 1) * 4096) >>> 15)};
            tbl[2*k+1] = '{1'b0, 16'h0000, 1'b0, 12'(((k + 1) * 4096) >>> 15)};
        end

        #12;
        check("reset_heading", heading, 0);
        check("reset_rdy", rdy, 0);
        check("reset_cal_done", cal_done, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;

        // Idle: samples ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 9'h0);

        // Calibration at offset 0x0040
        calibrate(16'h0040);
        check("cal_done_after_256", cal_done, 1);

        // Table: eight 0x1000 corrected steps reach heading 1
        for (int i = 0; i < 16; i++) begin
            step(1'b0, tbl[i].vld, tbl[i].yaw, 1'b1, 1'b0, 9'h0);
            check("tbl_rdy", rdy, tbl[i].exp_rdy);
            check("tbl_heading", heading, tbl[i].exp_hdg);
        end

        // Deadband: offset+10 treated as zero rate
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'h004A, 1'b1, 1'b0, 9'h0);
        check("deadband_heading", heading, 12'h001);
        // Not moving: heading frozen, rdy still pulses
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h1040, 1'b0, 1'b1, 9'h1F0);
        check("still_heading", heading, 12'h001);

        // Fusion: -16 << 4 = -256 per sample, 128 samples cancel the 0x8000 already accumulated
        for (int i = 0; i < 128; i++) step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 9'h1F0);
        check("fusion_heading", heading, 12'h000);
        for (int i = 0; i < 128; i++) step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 9'h1F0);
        check("fusion_wrap_heading", heading, 12'hFFF);

        // Restart collides with a sample: no rdy, heading cleared
        step(1'b1, 1'b1, 16'h1040, 1'b1, 1'b0, 9'h0);
        check("collide_rdy", rdy, 0);
        check("collide_heading", heading, 0);
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 16'hFFC0, 1'b0, 1'b0, 9'h0);
        check("recal_done", cal_done, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0FC0, 1'b1, 1'b0, 9'h0);
        check("recal_heading", heading, 12'h001);

        // Asynchronous reset between edges while rdy and heading are non-zero
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rdy", rdy, 0);
        check("async_rst_heading", heading, 0);
        check("async_rst_cal_done", cal_done, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h1040, 1'b1, 1'b0, 9'h0);

        // Randomized operation around a random offset
        begin
            logic [15:0] base;
            logic [15:0] y;
            base = 16'($urandom_range(0, 400)) - 16'd200;
            calibrate(base);
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 1) == 0)
                    y = base + 16'($urandom_range(0, 80)) - 16'd40;
                else
                    y = 16'($urandom);
                step(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), y,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 9'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
